pc_sequencer: RTL

//  Owns the program counter and sequences instruction fetch for the MIPS core.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_next_sel.sv | 27 ++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-state type and default PC parameters for the MIPS core
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_HALTED
  } fetch_state_t;

  localparam int          DEFAULT_AW       = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux: jump over branch over sequential +1 (wraps modulo 2^AW)
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic [AW-1:0] pc,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] next_pc,
  output logic          redirect
);

  always_comb begin
    redirect = jump | branch_taken;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc + AW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-gated, redirectable PC sequencer; BRANCH_DELAY_SLOT_EN defers redirects by one instruction
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int          AW       = DEFAULT_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  output logic          instr_valid,
  output logic [AW-1:0] pc_out,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          halt,
  output logic          halted
);

  fetch_state_t  state, state_nx;
  logic [AW-1:0] pc, pc_nx, pc_out_nx, sel_pc;
  logic          iv, iv_nx, redirect;
  logic          halt_q, halt_q_nx, halt_eff;
`ifdef BRANCH_DELAY_SLOT_EN
  logic          pend_valid, pend_valid_nx;
  logic [AW-1:0] pend_target, pend_target_nx, pc_inc;
  assign pc_inc = pc + AW'(1);
`endif

  pc_next_sel #(.AW(AW)) u_next_sel (
    .pc            (pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (sel_pc),
    .redirect      (redirect)
  );

  // halt is remembered so a one-cycle pulse still stops fetch once the in-flight request completes
  assign halt_eff    = halt | halt_q;
  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = iv;
  assign halted      = (state == ST_HALTED);

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    pc_out_nx = pc_out;
    iv_nx     = 1'b0;
    halt_q_nx = halt_eff;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_valid_nx  = pend_valid;
    pend_target_nx = pend_target;
`endif
    unique case (state)
      ST_IDLE: state_nx = ST_REQ;
      ST_REQ: begin
`ifdef BRANCH_DELAY_SLOT_EN
        if (redirect) begin
          pend_valid_nx  = 1'b1;
          pend_target_nx = sel_pc;
        end
        if (imem_ack) begin
          pc_out_nx = pc;
          iv_nx     = 1'b1;
          // the instruction just fetched is the delay slot when a redirect is pending
          if (pend_valid) begin
            pc_nx         = redirect ? sel_pc : pend_target;
            pend_valid_nx = 1'b0;
          end else begin
            pc_nx = pc_inc;
          end
          state_nx = stall ? ST_HOLD : (halt_eff ? ST_HALTED : ST_REQ);
        end
`else
        if (imem_ack || redirect) pc_nx = sel_pc;
        if (imem_ack && redirect) begin
          state_nx = halt_eff ? ST_HALTED : ST_REQ;
        end else if (imem_ack) begin
          pc_out_nx = pc;
          iv_nx     = 1'b1;
          state_nx  = stall ? ST_HOLD : (halt_eff ? ST_HALTED : ST_REQ);
        end
`endif
      end
      ST_HOLD: begin
        iv_nx = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        if (redirect) begin
          pend_valid_nx  = 1'b1;
          pend_target_nx = sel_pc;
        end
        if (!stall) begin
          iv_nx    = 1'b0;
          state_nx = halt_eff ? ST_HALTED : ST_REQ;
        end
`else
        if (redirect) pc_nx = sel_pc;
        if (redirect || !stall) begin
          iv_nx    = 1'b0;
          state_nx = halt_eff ? ST_HALTED : ST_REQ;
        end
`endif
      end
      ST_HALTED: state_nx = ST_HALTED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      pc_out <= RESET_PC;
      iv     <= 1'b0;
      halt_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_target <= RESET_PC;
`endif
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      pc_out <= pc_out_nx;
      iv     <= iv_nx;
      halt_q <= halt_q_nx;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid  <= pend_valid_nx;
      pend_target <= pend_target_nx;
`endif
    end
  end

endmodule
